// File: rtl/conv_channel_scheduler.sv
// ---------------------------------------------------------------------------
// conv_channel_scheduler
//
// Sequences a multi-channel convolution job through a streaming conv engine.
// For each input channel it forwards IMG_WIDTH*IMG_HEIGHT source pixels to
// the engine, pushes FLUSH_LEN zero pixels to drain the line buffers, then
// waits for the engine to finish the frame (end-of-frame pulse, full output
// count, or a bounded timeout) before moving to the next channel.
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous active-high reset
//   start          one-cycle job request, honoured only in IDLE
//   src_valid      source pixel valid
//   src_data       source pixel
//   src_ready      scheduler accepts a source pixel this cycle
//   eng_valid_in   pixel strobe to the conv engine (registered)
//   eng_data_in    pixel to the conv engine (registered, holds when idle)
//   eng_valid_out  engine output-pixel strobe
//   eng_done       engine end-of-frame pulse
//   ch_idx         current channel index
//   busy           high in every state except IDLE
//   ch_done        one-cycle pulse when a channel completes
//   job_done       one-cycle pulse when the last channel completes
//   timeout_err    sticky drain-timeout flag, cleared by reset or accepted start
// ---------------------------------------------------------------------------
module conv_channel_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 56,
    parameter int IMG_HEIGHT = 56,
    parameter int NUM_CH     = 64,
    parameter int FLUSH_LEN  = IMG_WIDTH + 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    output logic                  eng_valid_in,
    output logic [DATA_WIDTH-1:0] eng_data_in,
    input  logic                  eng_valid_out,
    input  logic                  eng_done,
    output logic [15:0]           ch_idx,
    output logic                  busy,
    output logic                  ch_done,
    output logic                  job_done,
    output logic                  timeout_err
);

    // state  | meaning
    // -------+------------------------------------------------------------
    // IDLE   | waiting for start; no job in progress
    // STREAM | forwarding source pixels of the current channel to the engine
    // FLUSH  | pushing FLUSH_LEN zero pixels, then one quiet cycle
    // DRAIN  | waiting for eng_done, a full output count, or the timeout
    // NEXT   | single cycle: advance channel or finish the job
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_FLUSH  = 3'd2,
        S_DRAIN  = 3'd3,
        S_NEXT   = 3'd4
    } state_t;

    localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
    // Counters hold the full frame count (out_cnt saturates there) and the
    // full flush length, so nothing wraps inside a channel.
    localparam int PIX_W   = $clog2(FRAME_PIX + 1);
    localparam int FLUSH_W = $clog2(FLUSH_LEN + 1);
    localparam int TMR_W   = $clog2(TIMEOUT + 1);

    localparam logic [PIX_W-1:0]   PIX_LAST  = PIX_W'(FRAME_PIX - 1);
    localparam logic [PIX_W-1:0]   PIX_TOTAL = PIX_W'(FRAME_PIX);
    localparam logic [FLUSH_W-1:0] FLUSH_END = FLUSH_W'(FLUSH_LEN);
    localparam logic [TMR_W-1:0]   TMR_LOAD  = TMR_W'(TIMEOUT - 1);
    localparam logic [15:0]        CH_LAST   = 16'(NUM_CH - 1);

    state_t                  state_q, state_d;
    logic [PIX_W-1:0]        pix_cnt_q, pix_cnt_d;
    logic [PIX_W-1:0]        out_cnt_q, out_cnt_d;
    logic [FLUSH_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic [TMR_W-1:0]        drain_tmr_q, drain_tmr_d;
    logic [15:0]             ch_idx_q, ch_idx_d;
    logic                    eng_valid_in_q, eng_valid_in_d;
    logic [DATA_WIDTH-1:0]   eng_data_in_q, eng_data_in_d;
    logic                    ch_done_q, ch_done_d;
    logic                    job_done_q, job_done_d;
    logic                    timeout_err_q, timeout_err_d;

    always_comb begin
        state_d        = state_q;
        pix_cnt_d      = pix_cnt_q;
        out_cnt_d      = out_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        drain_tmr_d    = drain_tmr_q;
        ch_idx_d       = ch_idx_q;
        eng_valid_in_d = 1'b0;
        eng_data_in_d  = eng_data_in_q;
        ch_done_d      = 1'b0;
        job_done_d     = 1'b0;
        timeout_err_d  = timeout_err_q;

        // The engine may start producing output while this channel is still
        // streaming or flushing, so output pulses count in all three phases.
        if ((state_q == S_STREAM || state_q == S_FLUSH || state_q == S_DRAIN) &&
            eng_valid_out && (out_cnt_q != PIX_TOTAL)) begin
            out_cnt_d = out_cnt_q + PIX_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                // job_done_q high means the previous job finished this very
                // cycle; a start coinciding with it is dropped.
                if (start && !job_done_q) begin
                    state_d       = S_STREAM;
                    ch_idx_d      = '0;
                    pix_cnt_d     = '0;
                    out_cnt_d     = '0;
                    timeout_err_d = 1'b0;
                end
            end

            S_STREAM: begin
                // src_ready is high for the whole state, so valid == accept.
                if (src_valid) begin
                    eng_valid_in_d = 1'b1;
                    eng_data_in_d  = src_data;
                    if (pix_cnt_q == PIX_LAST) begin
                        pix_cnt_d   = '0;
                        flush_cnt_d = '0;
                        state_d     = S_FLUSH;
                    end else begin
                        pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    end
                end
            end

            S_FLUSH: begin
                // FLUSH_LEN cycles register a zero pixel; the extra cycle at
                // the end lets the last one leave the output register before
                // DRAIN, so eng_valid_in is low for all of DRAIN.
                if (flush_cnt_q == FLUSH_END) begin
                    drain_tmr_d = TMR_LOAD;
                    state_d     = S_DRAIN;
                end else begin
                    eng_valid_in_d = 1'b1;
                    eng_data_in_d  = '0;
                    flush_cnt_d    = flush_cnt_q + FLUSH_W'(1);
                end
            end

            S_DRAIN: begin
                if (eng_done || (out_cnt_q == PIX_TOTAL)) begin
                    ch_done_d = 1'b1;
                    state_d   = S_NEXT;
                end else if (drain_tmr_q == '0) begin
                    timeout_err_d = 1'b1;
                    ch_done_d     = 1'b1;
                    state_d       = S_NEXT;
                end else begin
                    drain_tmr_d = drain_tmr_q - TMR_W'(1);
                end
            end

            S_NEXT: begin
                if (ch_idx_q == CH_LAST) begin
                    job_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    ch_idx_d  = ch_idx_q + 16'd1;
                    out_cnt_d = '0;
                    pix_cnt_d = '0;
                    state_d   = S_STREAM;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pix_cnt_q      <= '0;
            out_cnt_q      <= '0;
            flush_cnt_q    <= '0;
            drain_tmr_q    <= '0;
            ch_idx_q       <= '0;
            eng_valid_in_q <= 1'b0;
            eng_data_in_q  <= '0;
            ch_done_q      <= 1'b0;
            job_done_q     <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            pix_cnt_q      <= pix_cnt_d;
            out_cnt_q      <= out_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            drain_tmr_q    <= drain_tmr_d;
            ch_idx_q       <= ch_idx_d;
            eng_valid_in_q <= eng_valid_in_d;
            eng_data_in_q  <= eng_data_in_d;
            ch_done_q      <= ch_done_d;
            job_done_q     <= job_done_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    // Decoded straight from the state register so both drop with reset.
    assign src_ready    = (state_q == S_STREAM);
    assign busy         = (state_q != S_IDLE);
    assign eng_valid_in = eng_valid_in_q;
    assign eng_data_in  = eng_data_in_q;
    assign ch_idx       = ch_idx_q;
    assign ch_done      = ch_done_q;
    assign job_done     = job_done_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_conv_channel_scheduler.sv
module tb_conv_channel_scheduler;

    localparam int DW   = 32;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NCH  = 2;
    localparam int FL   = W + 1;
    localparam int TO   = 20;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          eng_valid_in;
    logic [DW-1:0] eng_data_in;
    logic          eng_valid_out;
    logic          eng_done;
    logic [15:0]   ch_idx;
    logic          busy;
    logic          ch_done;
    logic          job_done;
    logic          timeout_err;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
        bit            is_flush;
        bit            flush_last;
    } exp_t;

    exp_t exp_q[$];
    int   gap_q[$];
    bit   err_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int eng_mode = 0;        // 0: done pulse, 1: count pulses, 2: silent
    int done_at = -1;
    int last_flush_cyc = 0;
    int pix_in_ch = 0;
    bit in_post = 1'b0;
    int exp_ch = 0;
    int ch_done_cnt = 0;
    int job_done_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_channel_scheduler #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .NUM_CH     (NCH),
        .FLUSH_LEN  (FL),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_ready     (src_ready),
        .eng_valid_in  (eng_valid_in),
        .eng_data_in   (eng_data_in),
        .eng_valid_out (eng_valid_out),
        .eng_done      (eng_done),
        .ch_idx        (ch_idx),
        .busy          (busy),
        .ch_done       (ch_done),
        .job_done      (job_done),
        .timeout_err   (timeout_err)
    );

    // Scoreboard plus engine model, evaluated on the falling edge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            eng_valid_out = 1'b0;
            eng_done      = (eng_mode == 0) && (cyc == done_at);
            if (reset) begin
                exp_q.delete();
                pix_in_ch = 0;
                in_post   = 1'b0;
                exp_ch    = 0;
                done_at   = -1;
                eng_done  = 1'b0;
            end else begin
                if (in_post) begin
                    checks++;
                    if (src_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL src_ready_after_stream: got %b want 0 at cycle %0d", src_ready, cyc);
                    end
                end
                if (src_valid && src_ready) begin
                    e.data = src_data; e.due = cyc + 1; e.is_flush = 1'b0; e.flush_last = 1'b0;
                    exp_q.push_back(e);
                    pix_in_ch++;
                    if (pix_in_ch == NPIX) begin
                        for (int k = 1; k <= FL; k++) begin
                            e.data = '0; e.due = cyc + 1 + k; e.is_flush = 1'b1; e.flush_last = (k == FL);
                            exp_q.push_back(e);
                        end
                        pix_in_ch = 0;
                        in_post   = 1'b1;
                    end
                end
                if (eng_valid_in) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL eng_pixel: got unexpected pixel %h at cycle %0d want none", eng_data_in, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (eng_data_in !== e.data || cyc != e.due) begin
                            errors++;
                            $display("FAIL eng_pixel: got %h at cycle %0d want %h at cycle %0d",
                                     eng_data_in, cyc, e.data, e.due);
                        end
                        if (e.flush_last) begin
                            last_flush_cyc = cyc;
                            done_at        = cyc + 6;
                        end
                        if (!e.is_flush && eng_mode == 1) eng_valid_out = 1'b1;
                    end
                end
                if (ch_done) begin
                    ch_done_cnt++;
                    in_post = 1'b0;
                    gap_q.push_back(cyc - last_flush_cyc);
                    err_q.push_back(timeout_err);
                    checks++;
                    if (ch_idx !== 16'(exp_ch)) begin
                        errors++;
                        $display("FAIL ch_idx_at_ch_done: got %0d want %0d", ch_idx, exp_ch);
                    end
                    checks++;
                    if (exp_q.size() != 0) begin
                        errors++;
                        $display("FAIL pixels_pending_at_ch_done: got %0d want 0", exp_q.size());
                    end
                    exp_ch++;
                end
                if (job_done) begin
                    job_done_cnt++;
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_at_job_done: got %b want 0", busy);
                    end
                    exp_ch = 0;
                end
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_pixels(input int n, input bit toggle, input int start_at, output int sent);
        bit ph;
        int budget;
        sent = 0; ph = 1'b1; budget = 0;
        while (sent < n && budget < 1000) begin
            src_valid = toggle ? ph : 1'b1;
            src_data  = $urandom() | 32'h1;
            start     = (start_at >= 0) && (sent == start_at);
            @(negedge clk);
            if (src_valid && src_ready) sent++;
            ph = ~ph;
            @(posedge clk); #1;
            budget++;
        end
        src_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic wait_job(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(posedge clk); #1;
            if (job_done) ok = 1'b1;
        end
    endtask

    task automatic run_job(input string name, input int mode, input bit toggle, input int start_at,
                           input bit start_on_done, input int exp_gap, input bit exp_err);
        int sent;
        bit ok;
        int cd0;
        int jd0;
        cd0 = ch_done_cnt; jd0 = job_done_cnt;
        eng_mode = mode;
        gap_q.delete(); err_q.delete();
        pulse_start();
        checks++;
        if (ch_idx !== 16'd0 || busy !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL %s start_state: got ch_idx=%0d busy=%b timeout_err=%b want 0/1/0",
                     name, ch_idx, busy, timeout_err);
        end
        drive_pixels(NPIX * NCH, toggle, start_at, sent);
        checks++;
        if (sent != NPIX * NCH) begin
            errors++;
            $display("FAIL %s pixels_accepted: got %0d want %0d", name, sent, NPIX * NCH);
        end
        wait_job(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s job_done_timeout: got no job_done want job_done", name);
        end
        if (start_on_done && ok) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (busy !== 1'b0 || src_ready !== 1'b0 || ch_idx !== 16'(NCH - 1)) begin
                errors++;
                $display("FAIL %s start_on_job_done: got busy=%b src_ready=%b ch_idx=%0d want 0/0/%0d",
                         name, busy, src_ready, ch_idx, NCH - 1);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (ch_done_cnt - cd0 != NCH) begin
            errors++;
            $display("FAIL %s ch_done_count: got %0d want %0d", name, ch_done_cnt - cd0, NCH);
        end
        checks++;
        if (job_done_cnt - jd0 != 1) begin
            errors++;
            $display("FAIL %s job_done_count: got %0d want 1", name, job_done_cnt - jd0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_job: got %b want 0", name, busy);
        end
        foreach (gap_q[i]) begin
            checks++;
            if (gap_q[i] != exp_gap) begin
                errors++;
                $display("FAIL %s drain_length ch%0d: got %0d want %0d", name, i, gap_q[i], exp_gap);
            end
            checks++;
            if (err_q[i] !== exp_err) begin
                errors++;
                $display("FAIL %s timeout_err_at_ch_done ch%0d: got %b want %b", name, i, err_q[i], exp_err);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ch_idx, src_ready, eng_valid_in, eng_data_in, busy, ch_done, job_done, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ch_idx=%0d rdy=%b vin=%b din=%h busy=%b chd=%b jd=%b terr=%b want all 0",
                     ch_idx, src_ready, eng_valid_in, eng_data_in, busy, ch_done, job_done, timeout_err);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || src_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_start: got busy=%b src_ready=%b want 0/0", busy, src_ready);
        end
    endtask

    task automatic test_basic();
        run_job("basic", 0, 1'b0, -1, 1'b0, 7, 1'b0);
    endtask

    task automatic test_toggle();
        run_job("toggle", 0, 1'b1, -1, 1'b0, 7, 1'b0);
    endtask

    task automatic test_count_path();
        run_job("count_path", 1, 1'b0, -1, 1'b0, 2, 1'b0);
    endtask

    task automatic test_timeout();
        run_job("timeout", 2, 1'b0, -1, 1'b0, TO + 1, 1'b1);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b want 1", timeout_err);
        end
        run_job("after_timeout", 0, 1'b0, -1, 1'b0, 7, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_job("start_ignored", 0, 1'b0, 5, 1'b1, 7, 1'b0);
    endtask

    task automatic test_reset_mid_job();
        int sent;
        int cd0;
        int jd0;
        eng_mode = 0;
        pulse_start();
        drive_pixels(NPIX + 7, 1'b0, -1, sent);
        checks++;
        if (ch_idx !== 16'd1 || sent != NPIX + 7) begin
            errors++;
            $display("FAIL pre_reset_position: got ch_idx=%0d sent=%0d want 1/%0d", ch_idx, sent, NPIX + 7);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({ch_idx, src_ready, eng_valid_in, eng_data_in, busy, ch_done, job_done, timeout_err} !== '0) begin
            errors++;
            $display("FAIL mid_job_reset_outputs: got ch_idx=%0d rdy=%b vin=%b din=%h busy=%b chd=%b jd=%b terr=%b want all 0",
                     ch_idx, src_ready, eng_valid_in, eng_data_in, busy, ch_done, job_done, timeout_err);
        end
        cd0 = ch_done_cnt; jd0 = job_done_cnt;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (ch_done_cnt != cd0 || job_done_cnt != jd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abandoned_job: got ch_done=%0d job_done=%0d busy=%b want 0/0/0",
                     ch_done_cnt - cd0, job_done_cnt - jd0, busy);
        end
        run_job("restart", 0, 1'b0, -1, 1'b0, 7, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        src_valid     = 1'b0;
        src_data      = '0;
        eng_valid_out = 1'b0;
        eng_done      = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_toggle();
        test_count_path();
        test_timeout();
        test_start_ignored();
        test_reset_mid_job();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
